// File: rtl/rmii_rx_deframer_pkg.sv
// Shared RMII receive definitions.
//   RMII_PREAMBLE_DIBIT / RMII_SFD_DIBIT : line symbols seen LSB-first on RXD[1:0]
//   ETH_MIN_FRAME / ETH_MAX_FRAME        : frame byte limits, dst MAC..FCS inclusive
//   dfr_state_t                          : deframer state encoding
package rmii_rx_deframer_pkg;

    localparam logic [1:0] RMII_PREAMBLE_DIBIT = 2'b01;
    localparam logic [1:0] RMII_SFD_DIBIT      = 2'b11;
    localparam int         ETH_MIN_FRAME       = 64;
    localparam int         ETH_MAX_FRAME       = 1522;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_EOF,
        ST_DROP
    } dfr_state_t;

endpackage

// File: rtl/rmii_rx_deframer.sv
// RMII (100 Mb/s) receive deframer: strips preamble/SFD, packs LSB-first
// dibits into bytes, marks frame start/end and checks length/alignment.
// Ports:
//   clk_i, rst_i          50 MHz reference clock, synchronous active-high reset
//   rmii_rx_data_i[1:0]   RXD from the PHY
//   rmii_crs_dv_i         CRS_DV, used as plain data-valid
//   data_o, valid_o       received byte with one-cycle strobe
//   sof_o                 with valid_o on the first byte of a frame
//   eof_o                 one-cycle end-of-frame pulse; len_o/err_* valid here
//   len_o                 frame byte count (saturating), held until next eof_o
//   err_align_o           frame ended mid-byte
//   err_len_o             frame shorter than MIN_LEN or longer than MAX_LEN
//   busy_o                deframer not idle
module rmii_rx_deframer
    import rmii_rx_deframer_pkg::*;
#(
    parameter int PREAMBLE_MIN = 8,
    parameter int MIN_LEN      = ETH_MIN_FRAME,
    parameter int MAX_LEN      = ETH_MAX_FRAME,
    parameter int LEN_W        = 11
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [1:0]       rmii_rx_data_i,
    input  logic             rmii_crs_dv_i,
    output logic [7:0]       data_o,
    output logic             valid_o,
    output logic             sof_o,
    output logic             eof_o,
    output logic [LEN_W-1:0] len_o,
    output logic             err_align_o,
    output logic             err_len_o,
    output logic             busy_o
);

    localparam logic [3:0]       PMIN_C    = 4'(PREAMBLE_MIN);
    localparam logic [LEN_W-1:0] MIN_LEN_C = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);

    dfr_state_t       state;
    logic [1:0]       rxd_q;
    logic             crs_q;
    logic [3:0]       pcnt;
    logic [1:0]       dcnt;
    logic [5:0]       sreg;      // three most recent dibits; the 4th comes straight from rxd_q
    logic [LEN_W-1:0] len;
    logic             first;
    logic             over;

    logic [7:0]       byte_nxt;
    logic             len_sat;
    logic [LEN_W-1:0] len_inc;

    assign byte_nxt = {rxd_q, sreg};
    assign len_sat  = (len == '1);
    assign len_inc  = len_sat ? len : len + 1'b1;
    assign busy_o   = (state != ST_IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            rxd_q       <= '0;
            crs_q       <= 1'b0;
            pcnt        <= '0;
            dcnt        <= '0;
            sreg        <= '0;
            len         <= '0;
            first       <= 1'b0;
            over        <= 1'b0;
            data_o      <= '0;
            valid_o     <= 1'b0;
            sof_o       <= 1'b0;
            eof_o       <= 1'b0;
            len_o       <= '0;
            err_align_o <= 1'b0;
            err_len_o   <= 1'b0;
        end else begin
            rxd_q   <= rmii_rx_data_i;
            crs_q   <= rmii_crs_dv_i;
            valid_o <= 1'b0;
            sof_o   <= 1'b0;
            eof_o   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (crs_q) begin
                        if (rxd_q == RMII_PREAMBLE_DIBIT) begin
                            state <= ST_PREAMBLE;
                            pcnt  <= 4'd1;
                        end else begin
                            state <= ST_DROP;
                        end
                    end
                end
                ST_PREAMBLE: begin
                    if (!crs_q) begin
                        state <= ST_IDLE;
                    end else if (rxd_q == RMII_PREAMBLE_DIBIT) begin
                        if (pcnt != 4'hf) pcnt <= pcnt + 4'd1;
                    end else if (rxd_q == RMII_SFD_DIBIT && pcnt >= PMIN_C) begin
                        state <= ST_DATA;
                        dcnt  <= '0;
                        first <= 1'b1;
                        len   <= '0;
                        over  <= 1'b0;
                    end else begin
                        state <= ST_DROP;
                    end
                end
                ST_DATA: begin
                    if (!crs_q) begin
                        // Status is registered on the way into EOF so it lines up with eof_o.
                        state       <= ST_EOF;
                        eof_o       <= 1'b1;
                        len_o       <= len;
                        err_align_o <= (dcnt != 2'd0);
                        err_len_o   <= (len < MIN_LEN_C) | over;
                    end else begin
                        sreg <= byte_nxt[7:2];
                        dcnt <= dcnt + 2'd1;
                        if (dcnt == 2'd3) begin
                            len <= len_inc;
                            // Past MAX_LEN (or at counter saturation) bytes are swallowed.
                            if (!len_sat && len_inc <= MAX_LEN_C) begin
                                valid_o <= 1'b1;
                                data_o  <= byte_nxt;
                                sof_o   <= first;
                                first   <= 1'b0;
                            end else begin
                                over <= 1'b1;
                            end
                        end
                    end
                end
                ST_EOF:  state <= ST_IDLE;
                ST_DROP: if (!crs_q) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rmii_rx_deframer.sv
// Directed bench for rmii_rx_deframer. Each frame is described as a dibit
// list; a frame-level model turns it into per-cycle expectations (keyed by
// posedge count) that one compare process checks every cycle.
module tb_rmii_rx_deframer;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [1:0]  rxd;
    logic        crs;
    logic [7:0]  data_o;
    logic        valid_o, sof_o, eof_o, err_align_o, err_len_o, busy_o;
    logic [10:0] len_o;

    rmii_rx_deframer dut (
        .clk_i(clk), .rst_i(rst_i), .rmii_rx_data_i(rxd), .rmii_crs_dv_i(crs),
        .data_o(data_o), .valid_o(valid_o), .sof_o(sof_o), .eof_o(eof_o),
        .len_o(len_o), .err_align_o(err_align_o), .err_len_o(err_len_o),
        .busy_o(busy_o)
    );

    always #10 clk = ~clk;

    int ecnt = 0;
    always @(posedge clk) ecnt <= ecnt + 1;

    // expectations keyed by the posedge count at which they are visible
    bit          exp_v[int];
    logic [7:0]  exp_d[int];
    bit          exp_s[int];
    bit          exp_e[int];
    logic [10:0] exp_len[int];
    bit          exp_ea[int];
    bit          exp_el[int];
    bit          exp_b[int];
    bit          rst_s[int];

    logic [1:0]  fq[$];
    int          total = 0, bad = 0;
    int          last_idle = -100;
    bit          chk_en = 1'b0;
    logic [7:0]  hold_d = '0;
    logic [10:0] hold_len = '0;
    int          nvalid, nsof, neof, nerr;
    logic [10:0] eof_len;
    logic        eof_ea, eof_el;
    int          cc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, ecnt, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cc = ecnt;
            if (rst_s.exists(cc)) begin
                hold_d   = '0;
                hold_len = '0;
            end
            if (exp_v.exists(cc)) hold_d = exp_d[cc];
            check("valid", 32'(valid_o), 32'(exp_v.exists(cc)));
            check("sof",   32'(sof_o),   32'(exp_s.exists(cc)));
            check("eof",   32'(eof_o),   32'(exp_e.exists(cc)));
            check("busy",  32'(busy_o),  32'(exp_b.exists(cc)));
            check("data",  32'(data_o),  32'(hold_d));
            if (exp_e.exists(cc)) begin
                hold_len = exp_len[cc];
                check("err_align", 32'(err_align_o), 32'(exp_ea[cc]));
                check("err_len",   32'(err_len_o),   32'(exp_el[cc]));
            end
            check("len", 32'(len_o), 32'(hold_len));
            if (valid_o === 1'b1) nvalid++;
            if (sof_o === 1'b1) nsof++;
            if (eof_o === 1'b1) begin
                neof++;
                eof_len = len_o;
                eof_ea  = err_align_o;
                eof_el  = err_len_o;
                if (err_align_o === 1'b1 || err_len_o === 1'b1) nerr++;
            end
        end
    end

    task automatic set_busy(input int a, input int b);
        for (int t = a; t <= b; t++) exp_b[t] = 1'b1;
    endtask

    // Frame-level model over fq[first..last-1] (the dibits the deframer
    // actually sees). cut=1: a reset lands at slot s0+last, nothing later
    // from this part survives.
    task automatic model(input int s0, input int first, input int last, input bit cut);
        int k, n01, nb, rem, sl, lim, key;
        k = first; n01 = 0;
        while (k < last && fq[k] == 2'b01) begin n01++; k++; end
        sl  = s0 + last;
        lim = cut ? s0 + last : 32'h3fff_ffff;
        if (cut) rst_s[lim + 1] = 1'b1;
        if (k < last && fq[k] == 2'b11 && n01 >= 8) begin
            nb  = (last - k - 1) / 4;
            rem = (last - k - 1) % 4;
            for (int i = 0; i < nb; i++) begin
                key = s0 + k + 4 * i + 4 + 2;
                if (i < 1522 && key <= lim) begin
                    exp_v[key] = 1'b1;
                    exp_d[key] = {fq[k+4*i+4], fq[k+4*i+3], fq[k+4*i+2], fq[k+4*i+1]};
                    if (i == 0) exp_s[key] = 1'b1;
                end
            end
            if (cut) set_busy(s0 + first + 2, lim);
            else begin
                exp_e[sl+2]   = 1'b1;
                exp_len[sl+2] = (nb > 2047) ? 11'd2047 : 11'(nb);
                exp_ea[sl+2]  = (rem != 0);
                exp_el[sl+2]  = (nb < 64) || (nb > 1522);
                set_busy(s0 + first + 2, sl + 2);
                last_idle = sl + 3;
            end
        end else begin
            if (cut) set_busy(s0 + first + 2, lim);
            else begin
                set_busy(s0 + first + 2, sl + 1);
                last_idle = sl + 2;
            end
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int j = 0; j < 4; j++) fq.push_back(b[2*j +: 2]);
    endtask

    task automatic push_std_preamble();
        for (int j = 0; j < 7; j++) push_byte(8'h55);
        push_byte(8'hd5);
    endtask

    task automatic clear_counts();
        nvalid = 0; nsof = 0; neof = 0; nerr = 0;
        eof_len = '0; eof_ea = 1'b0; eof_el = 1'b0;
    endtask

    // Drive fq with crs high, then `gap` cycles of crs low. rst_idx>=0
    // pulses reset in the slot of that dibit.
    task automatic send(input int gap, input int rst_idx);
        int s0, first;
        @(negedge clk);
        s0 = ecnt;
        first = (last_idle - 1 - s0 > 0) ? last_idle - 1 - s0 : 0;
        if (rst_idx >= 0) begin
            model(s0, first, rst_idx, 1'b1);
            model(s0, rst_idx + 1, fq.size(), 1'b0);
        end else begin
            model(s0, first, fq.size(), 1'b0);
        end
        for (int i = 0; i < fq.size(); i++) begin
            if (i > 0) @(negedge clk);
            crs   = 1'b1;
            rxd   = fq[i];
            rst_i = (i == rst_idx);
            if (rst_idx >= 0 && i == rst_idx + 1) begin
                check("rst_valid", 32'(valid_o), 0);
                check("rst_data",  32'(data_o),  0);
                check("rst_len",   32'(len_o),   0);
                check("rst_busy",  32'(busy_o),  0);
                check("rst_eof",   32'(eof_o),   0);
            end
        end
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            crs = 1'b0; rxd = 2'b00; rst_i = 1'b0;
        end
        fq.delete();
    endtask

    initial begin
        rst_i = 1'b1; rxd = 2'b00; crs = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_valid", 32'(valid_o), 0);
        check("reset_eof",   32'(eof_o),   0);
        check("reset_busy",  32'(busy_o),  0);
        check("reset_len",   32'(len_o),   0);
        check("reset_data",  32'(data_o),  0);
        rst_i  = 1'b0;
        chk_en = 1'b1;

        // 64-byte clean frame
        clear_counts();
        push_std_preamble();
        for (int i = 0; i < 64; i++) push_byte(8'(i));
        send(6, -1);
        check("f64_nvalid", nvalid, 64);
        check("f64_neof", neof, 1);
        check("f64_len", 32'(eof_len), 64);
        check("f64_errs", {eof_ea, eof_el}, 0);

        // same frame plus two stray dibits
        clear_counts();
        push_std_preamble();
        for (int i = 0; i < 64; i++) push_byte(8'(i));
        fq.push_back(2'b01); fq.push_back(2'b10);
        send(6, -1);
        check("align_nvalid", nvalid, 64);
        check("align_len", 32'(eof_len), 64);
        check("align_err", 32'(eof_ea), 1);

        // short preamble: dropped silently
        clear_counts();
        for (int i = 0; i < 3; i++) fq.push_back(2'b01);
        fq.push_back(2'b11);
        for (int i = 0; i < 8; i++) push_byte(8'(i));
        send(6, -1);
        check("drop_nvalid", nvalid, 0);
        check("drop_neof", neof, 0);

        // runt frame
        clear_counts();
        push_std_preamble();
        for (int i = 0; i < 20; i++) push_byte(8'(i * 3));
        send(6, -1);
        check("runt_len", 32'(eof_len), 20);
        check("runt_err_len", 32'(eof_el), 1);

        // oversized frame
        clear_counts();
        push_std_preamble();
        for (int i = 0; i < 1530; i++) push_byte(8'(i));
        send(6, -1);
        check("giant_nvalid", nvalid, 1522);
        check("giant_len", 32'(eof_len), 1530);
        check("giant_err_len", 32'(eof_el), 1);

        // back-to-back with a one-cycle gap
        clear_counts();
        push_std_preamble();
        for (int i = 0; i < 64; i++) push_byte(8'(255 - i));
        send(1, -1);
        push_std_preamble();
        for (int i = 0; i < 64; i++) push_byte(8'(i + 7));
        send(6, -1);
        check("b2b_nsof", nsof, 2);
        check("b2b_neof", neof, 2);
        check("b2b_nerr", nerr, 0);

        // reset in the middle of the 30th byte, then a clean frame
        clear_counts();
        push_std_preamble();
        for (int i = 0; i < 64; i++) push_byte(8'(i));
        send(6, 32 + 29 * 4 + 2);
        check("rst_nvalid", nvalid, 29);
        check("rst_neof", neof, 0);
        clear_counts();
        push_std_preamble();
        for (int i = 0; i < 64; i++) push_byte(8'(i ^ 8'h5a));
        send(6, -1);
        check("post_rst_nvalid", nvalid, 64);
        check("post_rst_neof", neof, 1);
        check("post_rst_len", 32'(eof_len), 64);
        check("post_rst_errs", {eof_ea, eof_el}, 0);

        repeat (4) @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
